// File: rtl/axis_arb_pkg.sv
// Shared types and defaults for the two-source packet arbiter.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int MAX_BEATS_DEF  = 2048;
  localparam int CNT_WIDTH_DEF  = 16;

  // Beat counter must still be at least one bit wide for a one-beat limit
  function automatic int beat_cnt_width(input int max_beats);
    return (max_beats > 1) ? $clog2(max_beats) : 1;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-requester round-robin picker; a tie goes to the requester
// that did not win last time.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt
);

  // Winner selection from the current request pair
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = 1'b0;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt       = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt       = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt       = ~last_grant;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-stream FIFO write port
// between two sources; grants are held from first beat through tlast.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int max_beats  = MAX_BEATS_DEF,
  parameter int cnt_width  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] data_in0,
  input  logic                  s_axis_tvalid0,
  input  logic                  s_axis_tlast0,
  output logic                  s_axis_tready0,
  input  logic [data_width-1:0] data_in1,
  input  logic                  s_axis_tvalid1,
  input  logic                  s_axis_tlast1,
  output logic                  s_axis_tready1,
  output logic [data_width-1:0] data_out,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  grant,
  output logic                  busy,
  output logic [cnt_width-1:0]  pkt_cnt0,
  output logic [cnt_width-1:0]  pkt_cnt1,
  output logic                  err_overlen
);

  localparam int            BW        = beat_cnt_width(max_beats);
  localparam logic [BW-1:0] LAST_BEAT = BW'(max_beats - 1);

  state_t                state_r, state_nxt_s;
  logic                  grant_r, last_grant_r, err_r;
  logic [BW-1:0]         beat_cnt_r;
  logic [cnt_width-1:0]  cnt0_r, cnt1_r;
  logic                  gnt_valid_s, gnt_s;
  logic                  sel_valid_s, sel_last_s, at_limit_s, beat_s, pkt_end_s;
  logic [data_width-1:0] sel_data_s;

  rr_pick2 u_pick (
    .req        ({s_axis_tvalid1, s_axis_tvalid0}),
    .last_grant (last_grant_r),
    .gnt_valid  (gnt_valid_s),
    .gnt        (gnt_s)
  );

  // Select the granted source's stream signals
  always_comb begin
    sel_data_s  = data_in0;
    sel_valid_s = s_axis_tvalid0;
    sel_last_s  = s_axis_tlast0;
    if (grant_r) begin
      sel_data_s  = data_in1;
      sel_valid_s = s_axis_tvalid1;
      sel_last_s  = s_axis_tlast1;
    end else begin
      sel_data_s  = data_in0;
      sel_valid_s = s_axis_tvalid0;
      sel_last_s  = s_axis_tlast0;
    end
  end

  assign at_limit_s = (beat_cnt_r == LAST_BEAT);

  // Next state and pass-through outputs; the beat limit forces tlast on the output
  always_comb begin
    state_nxt_s    = state_r;
    data_out       = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s_axis_tready0 = 1'b0;
    s_axis_tready1 = 1'b0;
    beat_s         = 1'b0;
    pkt_end_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) state_nxt_s = BUSY;
        else             state_nxt_s = IDLE;
      end
      BUSY: begin
        data_out      = sel_data_s;
        m_axis_tvalid = sel_valid_s;
        m_axis_tlast  = sel_last_s | at_limit_s;
        if (grant_r) s_axis_tready1 = m_axis_tready;
        else         s_axis_tready0 = m_axis_tready;
        beat_s    = sel_valid_s & m_axis_tready;
        pkt_end_s = beat_s & (sel_last_s | at_limit_s);
        if (pkt_end_s) state_nxt_s = IDLE;
        else           state_nxt_s = BUSY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant, beat and packet bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      beat_cnt_r   <= '0;
      cnt0_r       <= '0;
      cnt1_r       <= '0;
      err_r        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE && gnt_valid_s) grant_r <= gnt_s;
      if (pkt_end_s) begin
        beat_cnt_r   <= '0;
        last_grant_r <= grant_r;
        if (!sel_last_s) err_r <= 1'b1;
        if (grant_r) cnt1_r <= cnt1_r + cnt_width'(1);
        else         cnt0_r <= cnt0_r + cnt_width'(1);
      end else if (beat_s) begin
        beat_cnt_r <= beat_cnt_r + BW'(1);
      end
    end
  end

  assign grant       = grant_r;
  assign busy        = (state_r == BUSY);
  assign pkt_cnt0    = cnt0_r;
  assign pkt_cnt1    = cnt1_r;
  assign err_overlen = err_r;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: queue-fed sources, a packet-level
// reference model checked every cycle, and directed literal expectations.
module tb_axis_pkt_arbiter;

  localparam int DW = 16;
  localparam int MB = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in0, data_in1, data_out;
  logic          s_axis_tvalid0, s_axis_tlast0, s_axis_tready0;
  logic          s_axis_tvalid1, s_axis_tlast1, s_axis_tready1;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          grant, busy, err_overlen;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.data_width(DW), .max_beats(MB), .cnt_width(CW)) dut (
    .clk(clk), .reset(reset),
    .data_in0(data_in0), .s_axis_tvalid0(s_axis_tvalid0), .s_axis_tlast0(s_axis_tlast0),
    .s_axis_tready0(s_axis_tready0),
    .data_in1(data_in1), .s_axis_tvalid1(s_axis_tvalid1), .s_axis_tlast1(s_axis_tlast1),
    .s_axis_tready1(s_axis_tready1),
    .data_out(data_out), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .grant(grant), .busy(busy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .err_overlen(err_overlen)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit check_en = 1'b0;
  bit hold0 = 1'b0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [15:0] log_d[$];
  bit          log_l[$];
  int          log_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present each source's queue head; hold0 models source 0 dropping tvalid
  task automatic drive();
    s_axis_tvalid0 = (q0.size() != 0) && !hold0;
    data_in0       = (q0.size() != 0) ? q0[0][15:0] : 16'h0000;
    s_axis_tlast0  = (q0.size() != 0) ? q0[0][16] : 1'b0;
    s_axis_tvalid1 = (q1.size() != 0);
    data_in1       = (q1.size() != 0) ? q1[0][15:0] : 16'h0000;
    s_axis_tlast1  = (q1.size() != 0) ? q1[0][16] : 1'b0;
  endtask

  task automatic push_pkt(input int src, input logic [15:0] base, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      if (src == 0) q0.push_back({with_last && (i == n - 1), base + 16'(i)});
      else          q1.push_back({with_last && (i == n - 1), base + 16'(i)});
    end
  endtask

  task automatic step();
    bit hs0, hs1;
    @(negedge clk);
    hs0 = s_axis_tvalid0 && s_axis_tready0;
    hs1 = s_axis_tvalid1 && s_axis_tready1;
    @(posedge clk);
    #1;
    cyc++;
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    drive();
  endtask

  task automatic run_idle(input string name);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy !== 1'b0) && k < 60) begin
      step();
      k++;
    end
    chk({name, "_timeout"}, 32'(k < 60), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    log_d.delete(); log_l.delete(); log_c.delete();
  endtask

  // Reference model: packet owner, beats so far, counters, sticky error
  bit m_busy = 1'b0, m_own = 1'b0, m_last = 1'b1, m_err = 1'b0;
  int m_beats = 0, m_cnt0 = 0, m_cnt1 = 0;
  logic exp_tvalid, exp_srclast, exp_limit;
  logic [15:0] exp_src_data;
  assign exp_tvalid   = m_busy && (m_own ? s_axis_tvalid1 : s_axis_tvalid0);
  assign exp_srclast  = m_own ? s_axis_tlast1 : s_axis_tlast0;
  assign exp_src_data = m_own ? data_in1 : data_in0;
  assign exp_limit    = (m_beats == MB - 1);

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_own <= 1'b0; m_last <= 1'b1; m_err <= 1'b0;
      m_beats <= 0; m_cnt0 <= 0; m_cnt1 <= 0;
    end else if (!m_busy) begin
      if (s_axis_tvalid0 || s_axis_tvalid1) begin
        m_busy <= 1'b1;
        if (s_axis_tvalid0 && s_axis_tvalid1) m_own <= !m_last;
        else                                  m_own <= s_axis_tvalid1;
      end
    end else if (exp_tvalid && m_axis_tready) begin
      if (exp_srclast || exp_limit) begin
        m_busy <= 1'b0; m_last <= m_own; m_beats <= 0;
        if (!exp_srclast) m_err <= 1'b1;
        if (m_own) m_cnt1 <= (m_cnt1 + 1) % (1 << CW);
        else       m_cnt0 <= (m_cnt0 + 1) % (1 << CW);
      end else begin
        m_beats <= m_beats + 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted beats
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      if (m_busy) chk("grant", 32'(grant), 32'(m_own));
      chk("m_tvalid", 32'(m_axis_tvalid), 32'(exp_tvalid));
      chk("tready0", 32'(s_axis_tready0), 32'(m_busy && !m_own && m_axis_tready));
      chk("tready1", 32'(s_axis_tready1), 32'(m_busy && m_own && m_axis_tready));
      if (exp_tvalid || !m_busy) begin
        chk("data_out", 32'(data_out), m_busy ? 32'(exp_src_data) : 32'd0);
        chk("m_tlast", 32'(m_axis_tlast), 32'(m_busy && (exp_srclast || exp_limit)));
      end
      chk("pkt_cnt0", 32'(pkt_cnt0), 32'(m_cnt0));
      chk("pkt_cnt1", 32'(pkt_cnt1), 32'(m_cnt1));
      chk("err_overlen", 32'(err_overlen), 32'(m_err));
      if (m_axis_tvalid && m_axis_tready && !reset) begin
        log_d.push_back(data_out);
        log_l.push_back(m_axis_tlast);
        log_c.push_back(cyc + 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [15:0] exp_order[8];
  int wrap_exp[5];
  int start, k;

  initial begin
    m_axis_tready = 1'b1;
    drive();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_cnt0", 32'(pkt_cnt0), 32'd0);
    chk("rst_err", 32'(err_overlen), 32'd0);
    reset = 1'b0;

    // Single 3-beat packet from source 0
    start = cyc;
    push_pkt(0, 16'hA000, 3, 1'b1);
    drive();
    run_idle("t1");
    chk("t1_nbeats", 32'(log_d.size()), 32'd3);
    if (log_d.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_data", 32'(log_d[i]), 32'(16'hA000 + 16'(i)));
        chk("t1_cycle", 32'(log_c[i] - start), 32'(i + 2));
        chk("t1_last", 32'(log_l[i]), 32'(i == 2));
      end
    end
    chk("t1_cnt0", 32'(pkt_cnt0), 32'd1);

    // Both sources requesting: strict alternation 0,1,0,1
    do_reset();
    push_pkt(0, 16'hA100, 2, 1'b1);
    push_pkt(1, 16'hB100, 2, 1'b1);
    push_pkt(0, 16'hA110, 2, 1'b1);
    push_pkt(1, 16'hB110, 2, 1'b1);
    drive();
    run_idle("t2");
    exp_order = '{16'hA100, 16'hA101, 16'hB100, 16'hB101, 16'hA110, 16'hA111, 16'hB110, 16'hB111};
    chk("t2_nbeats", 32'(log_d.size()), 32'd8);
    if (log_d.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t2_order", 32'(log_d[i]), 32'(exp_order[i]));
      chk("t2_gap", 32'(log_c[2] - log_c[1]), 32'd2);
    end
    chk("t2_cnt0", 32'(pkt_cnt0), 32'd2);
    chk("t2_cnt1", 32'(pkt_cnt1), 32'd2);

    // Output stall mid-packet, then source 0 drops tvalid while source 1 waits
    do_reset();
    push_pkt(0, 16'hA200, 3, 1'b1);
    push_pkt(1, 16'hB200, 1, 1'b1);
    drive();
    step();
    step();
    m_axis_tready = 1'b0;
    repeat (5) begin
      step();
      chk("t3_stall_tready0", 32'(s_axis_tready0), 32'd0);
      chk("t3_stall_data", 32'(data_out), 32'(16'hA201));
      chk("t3_stall_cnt0", 32'(pkt_cnt0), 32'd0);
    end
    m_axis_tready = 1'b1;
    hold0 = 1'b1;
    drive();
    repeat (3) begin
      step();
      chk("t3_hold_grant", 32'(grant), 32'd0);
      chk("t3_hold_busy", 32'(busy), 32'd1);
    end
    hold0 = 1'b0;
    drive();
    run_idle("t3");
    chk("t3_nbeats", 32'(log_d.size()), 32'd4);
    if (log_d.size() == 4) begin
      chk("t3_d1", 32'(log_d[1]), 32'(16'hA201));
      chk("t3_d2", 32'(log_d[2]), 32'(16'hA202));
      chk("t3_d3", 32'(log_d[3]), 32'(16'hB200));
    end
    chk("t3_cnt0", 32'(pkt_cnt0), 32'd1);
    chk("t3_cnt1", 32'(pkt_cnt1), 32'd1);

    // Runaway packet: source 1 sends 6 beats without tlast, limit is 4
    do_reset();
    push_pkt(1, 16'hB300, 6, 1'b0);
    drive();
    k = 0;
    while (pkt_cnt1 !== 2'd1 && k < 30) begin
      step();
      k++;
    end
    chk("t4_timeout", 32'(k < 30), 32'd1);
    chk("t4_cnt1", 32'(pkt_cnt1), 32'd1);
    chk("t4_err", 32'(err_overlen), 32'd1);
    chk("t4_nbeats", 32'(log_d.size()), 32'd4);
    if (log_d.size() == 4) begin
      chk("t4_l2", 32'(log_l[2]), 32'd0);
      chk("t4_forced_last", 32'(log_l[3]), 32'd1);
      chk("t4_d3", 32'(log_d[3]), 32'(16'hB303));
    end
    push_pkt(1, 16'hB306, 1, 1'b1);
    drive();
    run_idle("t4b");
    chk("t4_cnt1_b", 32'(pkt_cnt1), 32'd2);
    chk("t4_err_sticky", 32'(err_overlen), 32'd1);
    chk("t4_nbeats_b", 32'(log_d.size()), 32'd7);
    if (log_d.size() == 7) begin
      chk("t4_l4", 32'(log_l[4]), 32'd0);
      chk("t4_l6", 32'(log_l[6]), 32'd1);
    end

    // Reset on beat 2 of a 5-beat packet, tvalid held during reset
    do_reset();
    push_pkt(0, 16'hA400, 5, 1'b1);
    drive();
    step();
    step();
    reset = 1'b1;
    repeat (2) begin
      step();
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_tready0", 32'(s_axis_tready0), 32'd0);
      chk("t5_tready1", 32'(s_axis_tready1), 32'd0);
      chk("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("t5_cnt0", 32'(pkt_cnt0), 32'd0);
    end
    q0.delete();
    reset = 1'b0;
    log_d.delete(); log_l.delete(); log_c.delete();
    push_pkt(0, 16'hA410, 1, 1'b1);
    push_pkt(1, 16'hB410, 1, 1'b1);
    drive();
    run_idle("t5");
    chk("t5_nbeats", 32'(log_d.size()), 32'd2);
    if (log_d.size() == 2) begin
      chk("t5_first", 32'(log_d[0]), 32'(16'hA410));
      chk("t5_second", 32'(log_d[1]), 32'(16'hB410));
    end
    chk("t5_cnt0_after", 32'(pkt_cnt0), 32'd1);
    chk("t5_cnt1_after", 32'(pkt_cnt1), 32'd1);

    // Two-bit packet counter wrap
    do_reset();
    wrap_exp = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      push_pkt(0, 16'hA500 + 16'(i), 1, 1'b1);
      drive();
      run_idle("t6");
      chk("t6_wrap", 32'(pkt_cnt0), 32'(wrap_exp[i]));
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
